// File: rtl/cla_addsub_pipe.sv
// Pipelined add/sub/neg/absdiff built from 4-bit carry-lookahead groups.
// The group chain is cut into STAGES register slices, low groups first, under one global stall.
module cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] p, g, c;
  assign p = a_i ^ b_i;
  assign g = a_i & b_i;
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign c_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (&p & c_i);
  assign s_o  = p ^ c;
endmodule

module cla_addsub_pipe #(
  parameter int WIDTH  = 24,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic [1:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_swap
);
  localparam int NG = WIDTH / 4;
  localparam int L  = STAGES - 1;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_NEG = 2'd2, OP_ABS = 2'd3;

  logic              en;
  logic [STAGES:1]   vld_pipe;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d, ovf_q, ovf_d, swap_q, swap_d;

  assign o_valid = vld_pipe[STAGES];
  assign o_ready = i_ready | ~o_valid;
  assign en      = o_ready;

  // Every op becomes x + y + c; all but ADD use the inverted-B form, so carry-out is ~borrow.
  logic [WIDTH-1:0] x0, y0;
  logic             c0;
  always_comb begin
    x0 = i_a;
    y0 = ~i_b;
    c0 = 1'b1;
    case (i_op)
      OP_ADD: begin y0 = i_b; c0 = i_cin; end
      OP_SUB: c0 = ~i_cin;
      OP_NEG: x0 = '0;
      default: ;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * NG / STAGES;
    localparam int HI = (k + 1) * NG / STAGES;
    localparam int N  = HI - LO;

    logic [1:0]          op_in;
    logic                c_in, c_out;
    logic [WIDTH-1:4*LO] x_in, y_in;
    logic [4*HI-1:0]     s_out;
    logic [N:0]          cc;
    logic [4*N-1:0]      grp_sum;

    if (k == 0) begin : g_in
      assign op_in = i_op;
      assign c_in  = c0;
      assign x_in  = x0;
      assign y_in  = y0;
      assign s_out = grp_sum;
    end else begin : g_in
      // Stage input register: finished low sum bits plus the untouched high operand bits.
      logic [1:0]          op_q;
      logic                c_q;
      logic [WIDTH-1:4*LO] x_q, y_q;
      logic [4*LO-1:0]     s_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          op_q <= '0;
          c_q  <= 1'b0;
          x_q  <= '0;
          y_q  <= '0;
          s_q  <= '0;
        end else if (en) begin
          op_q <= g_stg[k-1].op_in;
          c_q  <= g_stg[k-1].c_out;
          x_q  <= g_stg[k-1].x_in[WIDTH-1:4*LO];
          y_q  <= g_stg[k-1].y_in[WIDTH-1:4*LO];
          s_q  <= g_stg[k-1].s_out;
        end
      end
      assign op_in = op_q;
      assign c_in  = c_q;
      assign x_in  = x_q;
      assign y_in  = y_q;
      assign s_out = {grp_sum, s_q};
    end

    assign cc[0] = c_in;
    assign c_out = cc[N];
    for (genvar g = 0; g < N; g++) begin : g_grp
      cla4 u_grp (
        .a_i (x_in[4*(LO+g) +: 4]),
        .b_i (y_in[4*(LO+g) +: 4]),
        .c_i (cc[g]),
        .s_o (grp_sum[4*g +: 4]),
        .c_o (cc[g+1])
      );
    end
  end

  logic [WIDTH-1:0] raw;
  logic             carry, xm, ym;
  logic [1:0]       opf;
  assign raw   = g_stg[L].s_out;
  assign carry = g_stg[L].c_out;
  assign xm    = g_stg[L].x_in[WIDTH-1];
  assign ym    = g_stg[L].y_in[WIDTH-1];
  assign opf   = g_stg[L].op_in;

  // ABSDIFF correction is a combinational negate ahead of the output register.
  always_comb begin
    swap_d   = (opf == OP_ABS) & ~carry;
    cout_d   = (opf == OP_ADD) ? carry : ~carry;
    ovf_d    = (opf != OP_ABS) & (xm == ym) & (raw[WIDTH-1] != xm);
    result_d = swap_d ? (~raw + WIDTH'(1)) : raw;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      swap_q   <= 1'b0;
    end else if (en) begin
      vld_pipe[1] <= i_valid;
      for (int j = 2; j <= STAGES; j++) vld_pipe[j] <= vld_pipe[j-1];
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      swap_q   <= swap_d;
    end
  end

  assign o_result = result_q;
  assign o_cout   = cout_q;
  assign o_ovf    = ovf_q;
  assign o_swap   = swap_q;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed table on the 24-bit/2-stage build plus
// random traffic on four builds scored against an arithmetic reference model.
module tb_cla_addsub_pipe;
  localparam int ND = 4;
  localparam int WS [ND] = '{24, 4, 32, 32};
  localparam int SS [ND] = '{2, 1, 8, 1};

  typedef struct {
    logic [31:0] res;
    logic        cout, ovf, swap;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [23:0] a, b;
    logic        cin;
    logic [23:0] res;
    logic        cout, ovf, swap;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n, i_valid, i_ready, cin;
  logic [1:0]    op;
  logic [31:0]   a, b;
  logic [ND-1:0] rdy, ov, co, of, sw;
  logic [31:0]   res [ND];

  int   n_vec = 0, n_miss = 0;
  exp_t expq [ND][$];
  logic held_v, acc0, out0;
  logic [63:0] held;
  logic [31:0] res0;

  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    localparam int W = WS[d];
    logic [W-1:0] r;
    cla_addsub_pipe #(.WIDTH(W), .STAGES(SS[d])) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy[d]),
      .i_a(a[W-1:0]), .i_b(b[W-1:0]), .i_cin(cin), .i_op(op),
      .o_valid(ov[d]), .i_ready(i_ready), .o_result(r),
      .o_cout(co[d]), .o_ovf(of[d]), .o_swap(sw[d])
    );
    assign res[d] = 32'(r);
  end

  // Reference: plain unsigned/signed integer arithmetic on the masked operands.
  function automatic exp_t model(int w, logic [1:0] o, logic [31:0] ai, logic [31:0] bi, logic c);
    exp_t   r;
    longint m, ua, ub, sa, sb, t, st;
    m  = longint'(1) << w;
    ua = longint'(ai) & (m - 1);
    ub = longint'(bi) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r.swap = 1'b0;
    r.ovf  = 1'b0;
    case (o)
      2'd0: begin
        t = ua + ub + longint'(c);  st = sa + sb + longint'(c);
        r.cout = (t >= m);
        r.ovf  = (st > m / 2 - 1) || (st < -(m / 2));
      end
      2'd1: begin
        t = ua - ub - longint'(c);  st = sa - sb - longint'(c);
        r.cout = (ua < ub + longint'(c));
        r.ovf  = (st > m / 2 - 1) || (st < -(m / 2));
      end
      2'd2: begin
        t = -ub;
        r.cout = (ub != 0);
        r.ovf  = (ub == m / 2);
      end
      default: begin
        t = (ua >= ub) ? ua - ub : ub - ua;
        r.cout = (ua < ub);
        r.swap = (ua < ub);
      end
    endcase
    r.res = 32'(t & (m - 1));
    return r;
  endfunction

  function automatic logic [63:0] pk(logic v, logic c, logic o, logic s, logic [31:0] r);
    return {28'b0, v, c, o, s, r};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // One cycle: score at the falling edge, then step to just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    acc0 = i_valid && rdy[0];
    out0 = ov[0] && i_ready;
    res0 = res[0];
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) expq[d].delete();
      else begin
        if (ov[d] && i_ready) begin
          if (expq[d].size() == 0) chk($sformatf("spurious%0d", d), 64'd1, 64'd0);
          else begin
            e = expq[d].pop_front();
            chk($sformatf("dut%0d", d), pk(1'b1, co[d], of[d], sw[d], res[d]),
                pk(1'b1, e.cout, e.ovf, e.swap, e.res));
          end
        end
        if (i_valid && rdy[d]) expq[d].push_back(model(WS[d], op, a, b, cin));
      end
    end
    if (rst_n && held_v) chk("hold", pk(ov[0], co[0], of[0], sw[0], res[0]), held);
    held_v = rst_n && ov[0] && !i_ready;
    held   = pk(ov[0], co[0], of[0], sw[0], res[0]);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [31:0] ai, input logic [31:0] bi, input logic c);
    op = o; a = ai; b = bi; cin = c; i_valid = 1'b1;
  endtask

  vec_t tbl [14];
  exp_t e1;
  int   idx, got;

  initial begin
    tbl[0]  = '{2'd0, 24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{2'd1, 24'h000005, 24'h000007, 1'b0, 24'hFFFFFE, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{2'd0, 24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{2'd3, 24'h000003, 24'h000010, 1'b0, 24'h00000D, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{2'd2, 24'h000000, 24'h800000, 1'b0, 24'h800000, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{2'd0, 24'h123456, 24'h654321, 1'b1, 24'h777778, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{2'd1, 24'h800000, 24'h000001, 1'b0, 24'h7FFFFF, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{2'd1, 24'h000010, 24'h000010, 1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{2'd2, 24'hABCDEF, 24'h000000, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{2'd3, 24'h000010, 24'h000003, 1'b1, 24'h00000D, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{2'd3, 24'h555555, 24'h555555, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{2'd2, 24'h123456, 24'h000001, 1'b0, 24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{2'd3, 24'h000000, 24'hFFFFFF, 1'b0, 24'hFFFFFF, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{2'd0, 24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b1; i_valid = 1'b0; i_ready = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    held_v = 1'b0; held = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ov_rdy", 64'({ov, rdy}), 64'((1 << ND) - 1));
    chk("rst_out", pk(ov[0], co[0], of[0], sw[0], res[0]), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1; i_ready = 1'b1;
    tick();

    // Directed table, one op at a time, exact latency on the 24/2 build.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].op, 32'(tbl[i].a), 32'(tbl[i].b), tbl[i].cin);
      tick();
      i_valid = 1'b0;
      for (int s = 1; s < SS[0]; s++) begin
        chk($sformatf("early%0d", i), 64'(ov[0]), 64'd0);
        tick();
      end
      chk($sformatf("tbl%0d", i), pk(ov[0], co[0], of[0], sw[0], res[0]),
          pk(1'b1, tbl[i].cout, tbl[i].ovf, tbl[i].swap, 32'(tbl[i].res)));
    end
    tick();

    // Eight back-to-back ops with a three-cycle downstream stall in the middle.
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      i_ready = !(cyc >= 4 && cyc < 7);
      if (idx < 8) drive(2'd0, 32'(idx * 24'h010101 + 5), 32'(idx), 1'b0);
      else i_valid = 1'b0;
      tick();
      if (acc0) idx++;
      if (out0) begin
        chk($sformatf("seq%0d", got), 64'(res0), 64'((got * 24'h010101 + 5 + got) & 24'hFFFFFF));
        got++;
      end
    end
    chk("seq_count", 64'(got), 64'd8);
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (10) tick();

    // Reset with two ops in flight.
    drive(2'd0, 32'd10, 32'd20, 1'b0);
    tick();
    drive(2'd0, 32'd30, 32'd40, 1'b0);
    tick();
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ov_rdy", 64'({ov, rdy}), 64'((1 << ND) - 1));
    chk("midrst_out", pk(ov[0], co[0], of[0], sw[0], res[0]), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stale%0d", i), 64'(ov), 64'd0);
    end
    drive(2'd1, 32'd7, 32'd9, 1'b0);
    e1 = model(24, 2'd1, 32'd7, 32'd9, 1'b0);
    tick();
    i_valid = 1'b0;
    repeat (SS[0] - 1) tick();
    chk("post_rst", pk(ov[0], co[0], of[0], sw[0], res[0]), pk(1'b1, e1.cout, e1.ovf, e1.swap, e1.res));
    repeat (10) tick();

    // Random traffic on all builds with random bubbles and backpressure.
    for (int i = 0; i < 3000; i++) begin
      op  = 2'($urandom_range(3));
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(1));
      case ($urandom_range(7))
        0: b = a;
        1: begin a = 32'h8000_0000 >> (4 * $urandom_range(2)); b = a; op = 2'd2; end
        2: b = 32'h0080_0008;
        default: ;
      endcase
      i_valid = ($urandom_range(9) < 7);
      i_ready = ($urandom_range(3) != 0);
      tick();
    end

    i_valid = 1'b0; i_ready = 1'b1;
    repeat (20) tick();
    for (int d = 0; d < ND; d++) chk($sformatf("drain%0d", d), 64'(expq[d].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/cla_addsub_pipe.md
CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 24, operand/result width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL provide parameter STAGES, default 2, number of register stages; legal values are 1 to WIDTH/4.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_valid, input, 1, input operands valid.
REQ-006 SHALL have port o_ready, output, 1, block accepts input this cycle.
REQ-007 SHALL have port i_a, input, WIDTH, operand A (unsigned or two's complement).
REQ-008 SHALL have port i_b, input, WIDTH, operand B.
REQ-009 SHALL have port i_cin, input, 1, carry-in for ADD or borrow-in for SUB; ignored in NEG and ABSDIFF.
REQ-010 SHALL have port i_op, input, 2, operation select: 00 ADD, 01 SUB, 10 NEG, 11 ABSDIFF.
REQ-011 SHALL have port o_valid, output, 1, result valid.
REQ-012 SHALL have port i_ready, input, 1, downstream accepts result.
REQ-013 SHALL have port o_result, output, WIDTH, result.
REQ-014 SHALL have port o_cout, output, 1, carry-out (ADD) or borrow-out (SUB, NEG, ABSDIFF pre-correction).
REQ-015 SHALL have port o_ovf, output, 1, signed overflow flag.
REQ-016 SHALL have port o_swap, output, 1, set in ABSDIFF when B > A (unsigned).

Function
REQ-017 Arithmetic SHALL use 4-bit carry-lookahead groups with group generate/propagate and ripple or lookahead between groups.
REQ-018 Group boundaries SHALL be registered so the WIDTH/4 groups split into STAGES contiguous slices, low bits first; unprocessed high operand bits and the op SHALL be carried in the pipeline registers.
REQ-019 ADD: o_result = (A + B + i_cin) mod 2^WIDTH, o_cout = carry out of MSB.
REQ-020 SUB: o_result = (A − B − i_cin) mod 2^WIDTH, o_cout = 1 iff A < B + i_cin (unsigned).
REQ-021 NEG: o_result = (0 − B) mod 2^WIDTH, o_cout = 1 iff B ≠ 0; i_a ignored.
REQ-022 ABSDIFF: o_result = |A − B| (unsigned), o_swap = o_cout = 1 iff A < B; the conditional two's-complement correction SHALL occur in the final stage with no added latency.
REQ-023 o_ovf SHALL be signed overflow for ADD and SUB, set for NEG only when B = 100...0, and 0 for ABSDIFF; o_swap SHALL be 0 for all ops except ABSDIFF.
REQ-024 Latency SHALL be exactly STAGES cycles from an accepted input (i_valid & o_ready) to o_valid, absent backpressure.
REQ-025 Throughput SHALL be one operation per cycle; results SHALL emerge in acceptance order.
REQ-026 o_ready SHALL equal i_ready | ~o_valid (global stall); when o_valid & ~i_ready, all stages and outputs SHALL hold.
REQ-027 Bubbles (i_valid=0 while accepting) SHALL propagate as invalid slots; o_valid SHALL never assert for a bubble.
REQ-028 o_result/o_cout/o_ovf/o_swap SHALL be stable while o_valid=1 and i_ready=0.
REQ-029 Operands applied when input is not accepted SHALL have no effect.

Reset
REQ-030 i_rst_n low SHALL asynchronously clear all stage valid bits and o_valid, o_result, o_cout, o_ovf, o_swap to 0.
REQ-031 Reset mid-operation SHALL discard all in-flight operations; first accepted input after reset release SHALL emerge after STAGES cycles.
REQ-032 During reset o_ready SHALL be 1 (o_valid = 0).

Verification
REQ-033 WIDTH=24, STAGES=2, ADD A=0xFFFFFF, B=0x000001, cin=0 -> after 2 cycles o_result=0x000000, o_cout=1, o_ovf=0.
REQ-034 SUB A=0x000005, B=0x000007, cin=0 -> o_result=0xFFFFFE, o_cout=1; ADD A=0x7FFFFF, B=1 -> o_ovf=1.
REQ-035 ABSDIFF A=0x000003, B=0x000010 -> o_result=0x00000D, o_swap=1; NEG B=0x800000 -> o_result=0x800000, o_ovf=1.
REQ-036 Back-to-back 8 inputs with i_ready low for 3 cycles mid-stream -> all 8 results in order, none lost or duplicated, outputs held during stall.
REQ-037 Assert i_rst_n low with 2 ops in flight -> o_valid=0 immediately; no stale result after release.
REQ-038 Random regression for WIDTH in {4,24,32}, STAGES in {1,max}, all ops, random i_valid/i_ready -> results match golden model.
